mem_stage: RTL

- Memory-access stage of the LEGv8 5-stage pipeline, directly downstream of EX.
- Consumes the EX result (ALUOut as address or arithmetic result) plus the store data and control bits from the EX/MEM boundary.
- Drives a request/ready data-memory bus and stalls upstream while an access is outstanding.
- Registers the MEM/WB result for write-back.

---
 rtl/mem_stage_if.sv | 29 ++
 rtl/mem_stage.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and memory (slave).
interface mem_stage_if #(
    parameter int unsigned WORD = 64
);
    logic            dmem_req;
    logic            dmem_we;
    logic [WORD-1:0] dmem_addr;
    logic [WORD-1:0] dmem_wdata;
    logic [WORD-1:0] dmem_rdata;
    logic            dmem_ready;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ready
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ready
    );
endinterface

// File: rtl/mem_stage.sv
// LEGv8 MEM stage: issues loads/stores on the dmem bus, stalls upstream while an
// access is outstanding, faults on misalignment or bus timeout, and registers MEM/WB.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned WORD    = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic [WORD-1:0] ALUOut,
    input  logic [WORD-1:0] w_data,
    input  logic [4:0]      rd,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic            RegWrite,
    input  logic            MemtoReg,
    output logic            stall,
    mem_stage_if.master     dmem,
    output logic            wb_valid,
    output logic            wb_RegWrite,
    output logic [4:0]      wb_rd,
    output logic [WORD-1:0] wb_data,
    output logic            mem_fault
);

    localparam int unsigned     TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;

    logic mem_op;
    logic accept;
    logic pass;
    logic misalign;
    logic complete;
    logic timeout;

    // A store wins when both MemRead and MemWrite are set: the bus we bit is MemWrite.
    assign mem_op = MemRead | MemWrite;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, stall and per-cycle event flags.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        accept     = 1'b0;
        pass       = 1'b0;
        misalign   = 1'b0;
        complete   = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (ex_valid) begin
                    if (mem_op) begin
                        if (ALUOut[2:0] == 3'b000) begin
                            accept     = 1'b1;
                            stall      = 1'b1;
                            state_next = ACCESS;
                        end else begin
                            misalign = 1'b1;
                        end
                    end else begin
                        pass = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // Ready in the last allowed cycle still counts as a normal completion.
                if (dmem.dmem_ready) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (timer == TLAST) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // Stall is combinational, so it is forced low while reset is held.
        if (!rst_n) begin
            stall = 1'b0;
        end
    end

    // Bus request registers and access timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            timer           <= '0;
        end else begin
            if (accept) begin
                dmem.dmem_req   <= 1'b1;
                dmem.dmem_we    <= MemWrite;
                dmem.dmem_addr  <= ALUOut;
                dmem.dmem_wdata <= w_data;
                timer           <= '0;
            end else if (complete || timeout) begin
                dmem.dmem_req <= 1'b0;
            end else if (state == ACCESS) begin
                timer <= timer + 1'b1;
            end
        end
    end

    // MEM/WB result registers and fault pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            mem_fault   <= 1'b0;
        end else begin
            wb_valid    <= pass | misalign | complete | timeout;
            wb_RegWrite <= (pass | complete) & RegWrite;
            mem_fault   <= misalign | timeout;
            if (pass | misalign | complete | timeout) begin
                wb_rd <= rd;
            end
            if (pass) begin
                wb_data <= ALUOut;
            end else if (complete) begin
                wb_data <= MemtoReg ? dmem.dmem_rdata : ALUOut;
            end else if (misalign | timeout) begin
                wb_data <= '0;
            end
        end
    end

endmodule
